// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared widths, FSM state type and rounding constant
// Contents:
//   DATA_W_DEF/COEF_W_DEF/ADDR_W_DEF : default sample, coefficient, half-table address widths
//   state_t                          : frame FSM states
//   round_const()/ROUND_CONST        : half-LSB added before the Q1.(COEF_W-1) shift
package window_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic longint round_const(input int coef_w);
    return longint'(1) << (coef_w - 2);
  endfunction

  localparam longint ROUND_CONST = round_const(COEF_W_DEF);

endpackage

// File: rtl/window_mult_stream_if.sv
// rtl/window_mult_stream_if.sv - input and output sample streams of the window multiplier
// Ports (signals):
//   s_valid/s_ready/s_data          : input sample stream
//   m_valid/m_ready/m_data/m_last   : windowed output stream, m_last marks end of frame
// Modports: slave = window block, master = sample source / sink
interface window_mult_stream_if
  import window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/window_coef_ram.sv
// rtl/window_coef_ram.sv - simple dual-port read-first coefficient table
// Ports:
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read enable and address
//   rdata        : registered read data (old contents on same-address write)
// Contents are deliberately not reset.
module window_coef_ram #(
  parameter int COEF_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COEF_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [COEF_W-1:0] rdata
);
  logic [COEF_W-1:0] mem [2**ADDR_W];

  // Both accesses in one block: the read samples mem before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/window_mult_stream.sv
// rtl/window_mult_stream.sv - streaming symmetric-window multiplier
// Ports:
//   clk, reset                        : clock, async active-high reset
//   frame_len                         : frame length N, sampled on the first accept of a frame
//   coef_we/coef_waddr/coef_wdata     : half-window table write port
//   bus (slave)                       : s_* input stream, m_* output stream with m_last
//   busy                              : frame in progress or samples still in the pipeline
module window_mult_stream
  import window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W:0]      frame_len,
  input  logic                 coef_we,
  input  logic [ADDR_W-1:0]    coef_waddr,
  input  logic [COEF_W-1:0]    coef_wdata,
  window_mult_stream_if.slave  bus,
  output logic                 busy
);
  localparam int NW = ADDR_W + 1;
  localparam int PW = DATA_W + COEF_W + 1;
  localparam logic signed [PW-1:0] RND  = PW'(round_const(COEF_W));
  localparam logic signed [PW-1:0] MAXV = PW'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  state_t                     state;
  logic [NW-1:0]              k, n_reg;
  logic                       en, acc;
  logic [NW-1:0]              n_in, n_cur, k_cur;
  logic [NW:0]                half;
  logic [ADDR_W-1:0]          raddr;
  logic                       is_last;
  logic [COEF_W-1:0]          coef;
  logic                       v1, l1, v2, l2;
  logic signed [DATA_W-1:0]   d1;
  logic signed [PW-1:0]       prod_c, prod, sum, shifted;
  logic [DATA_W-1:0]          sat;

  // One enable for every stage: the pipeline only moves when the output slot frees up.
  assign en          = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = en;
  assign acc         = bus.s_valid && en;

  // In IDLE the incoming sample is index 0 of a frame whose length is taken from frame_len now.
  assign n_in    = (frame_len < NW'(2)) ? NW'(2) : frame_len;
  assign n_cur   = (state == IDLE) ? n_in : n_reg;
  assign k_cur   = (state == IDLE) ? '0 : k;
  assign half    = ({1'b0, n_cur} + (NW+1)'(1)) >> 1;
  // Mirror address is below half, so its low ADDR_W bits are exact.
  assign raddr   = ({1'b0, k_cur} < half) ? k_cur[ADDR_W-1:0]
                 : n_cur[ADDR_W-1:0] - k_cur[ADDR_W-1:0] - ADDR_W'(1);
  assign is_last = (k_cur == n_cur - NW'(1));

  window_coef_ram #(.COEF_W(COEF_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (coef_we),
    .waddr (coef_waddr),
    .wdata (coef_wdata),
    .re    (en),
    .raddr (raddr),
    .rdata (coef)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      n_reg <= '0;
    end else if (acc) begin
      case (state)
        IDLE: begin
          n_reg <= n_in;
          k     <= NW'(1);
          state <= RUN;
        end
        RUN: begin
          if (is_last) begin
            k     <= '0;
            state <= IDLE;
          end else begin
            k <= k + NW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Coefficients are unsigned Q1.x, so zero-extend before the signed multiply.
  assign prod_c  = $signed({{(PW-DATA_W){d1[DATA_W-1]}}, d1}) * $signed({{(PW-COEF_W){1'b0}}, coef});
  assign sum     = prod + RND;
  assign shifted = sum >>> (COEF_W - 1);
  assign sat     = (shifted > MAXV) ? MAXV[DATA_W-1:0]
                 : (shifted < MINV) ? MINV[DATA_W-1:0] : shifted[DATA_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1          <= 1'b0;
      l1          <= 1'b0;
      d1          <= '0;
      v2          <= 1'b0;
      l2          <= 1'b0;
      prod        <= '0;
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      bus.m_data  <= '0;
    end else if (en) begin
      v1          <= acc;
      l1          <= acc && is_last;
      d1          <= bus.s_data;
      v2          <= v1;
      l2          <= v1 && l1;
      prod        <= prod_c;
      bus.m_valid <= v2;
      bus.m_last  <= v2 && l2;
      if (v2) bus.m_data <= sat;
    end
  end

  assign busy = (state == RUN) || v1 || v2 || bus.m_valid;
endmodule

// File: tb/tb_window_mult_stream.sv
// tb/tb_window_mult_stream.sv - scoreboard bench for window_mult_stream
module tb_window_mult_stream;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  frame_len;
  logic        coef_we;
  logic [8:0]  coef_waddr;
  logic [15:0] coef_wdata;
  logic        busy;

  window_mult_stream_if #(.DATA_W(16)) bus ();

  window_mult_stream #(.DATA_W(16), .COEF_W(16), .ADDR_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_len  (frame_len),
    .coef_we    (coef_we),
    .coef_waddr (coef_waddr),
    .coef_wdata (coef_wdata),
    .bus        (bus),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          tab[512];
  int          stall_cycles = 0;
  logic [15:0] prev_d;
  logic        prev_l;
  bit          prev_st = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int model(input int d, input int c);
    longint p = longint'(d) * longint'(c) + 64'sd16384;
    longint r = p / 32768;
    if (p < 0 && (p % 32768) != 0) r = r - 1;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  always @(posedge clk) begin
    #1;
    if (stall_cycles > 0) begin
      bus.m_ready = 1'b0;
      stall_cycles = stall_cycles - 1;
    end else begin
      bus.m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_st = 0;
    end else begin
      if (prev_st && bus.m_valid) begin
        check("hold_data", bus.m_data, prev_d);
        check("hold_last", bus.m_last, prev_l);
      end
      if (bus.m_valid && !bus.m_ready) check("s_ready_stall", bus.s_ready, 0);
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0d required=none", $signed(bus.m_data));
        end else begin
          e = q.pop_front();
          check("out_data", $signed(bus.m_data), $signed(e.d));
          check("out_last", bus.m_last, e.l);
        end
      end
      prev_st = bus.m_valid && !bus.m_ready;
      prev_d  = bus.m_data;
      prev_l  = bus.m_last;
    end
  end

  task automatic wr_coef(input int a, input int c);
    coef_we = 1'b1;
    coef_waddr = 9'(a);
    coef_wdata = 16'(c);
    tab[a] = c;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] ed, input logic el, input bit push);
    int t = 0;
    bus.s_valid = 1'b1;
    bus.s_data = d;
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      t++;
      if (t > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=%0d required=accept", t);
        bus.s_valid = 1'b0;
        return;
      end
    end
    if (push) q.push_back('{d: ed, l: el});
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int n, input int d, input int abort_k);
    for (int k = 0; k < n; k++) begin
      int a = (k < (n + 1) / 2) ? k : n - 1 - k;
      send(16'(d), 16'(model(d, tab[a])), k == n - 1, (abort_k < 0) || (k <= abort_k - 3));
      if (k == abort_k) return;
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b1;
    frame_len = 10'd100;
    coef_we = 1'b0;
    coef_waddr = '0;
    coef_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_s_ready", bus.s_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 50; i++) begin
      real w = (0.54 - 0.46 * $cos(2.0 * 3.141592653589793 * i / 99.0)) * 32768.0;
      wr_coef(i, $rtoi(w + 0.5));
    end

    // Hamming frame: latency, stall in the middle, frame_len change ignored mid-frame
    frame_len = 10'd100;
    send(16'h4000, 16'h051F, 1'b0, 1);
    bus.s_valid = 1'b0;
    @(negedge clk); check("lat_c1", bus.m_valid, 0);
    @(negedge clk); check("lat_c2", bus.m_valid, 0);
    @(negedge clk); check("lat_c3", bus.m_valid, 1);
    @(posedge clk); #1;
    for (int k = 1; k < 100; k++) begin
      int a = (k < 50) ? k : 99 - k;
      if (k == 10) frame_len = 10'd8;
      if (k == 50) stall_cycles = 5;
      if (k == 99) send(16'h4000, 16'h051F, 1'b1, 1);
      else send(16'h4000, 16'(model(16384, tab[a])), 1'b0, 1);
    end
    run_frame(8, 16384, -1);
    frame_len = 10'd0;
    run_frame(2, 1234, -1);
    run_frame(2, -1234, -1);
    bus.s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // N=5 hand vectors
    wr_coef(0, 1000);
    wr_coef(1, 2000);
    wr_coef(2, 3000);
    frame_len = 10'd5;
    send(16'h7FFF, 16'd1000, 1'b0, 1);
    send(16'h7FFF, 16'd2000, 1'b0, 1);
    send(16'h7FFF, 16'd3000, 1'b0, 1);
    send(16'h7FFF, 16'd2000, 1'b0, 1);
    send(16'h7FFF, 16'd1000, 1'b1, 1);
    bus.s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Full-scale extremes
    wr_coef(0, 32767);
    frame_len = 10'd2;
    send(16'h8000, 16'h8001, 1'b0, 1);
    send(16'h7FFF, 16'h7FFE, 1'b1, 1);
    bus.s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Reset after accepting k=37: samples 35..37 must never appear
    frame_len = 10'd100;
    run_frame(100, 4096, 37);
    reset = 1'b1;
    bus.s_valid = 1'b0;
    check("abort_queue", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_m_valid", bus.m_valid, 0);
    check("abort_busy", busy, 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    frame_len = 10'd6;
    run_frame(6, 8192, -1);
    bus.s_valid = 1'b0;

    for (int t = 0; t < 1000 && q.size() != 0; t++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("drain_queue", q.size(), 0);
    check("end_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
